fixed_softplus_requant: RTL
===========================

Name: fixed_softplus_requant

Overview:
Downstream neighbour of fixed_softplus. It consumes the wide fixed-point activation stream and converts it to the narrower fixed-point format used by the next layer.
- Conversion per element: round-to-nearest, then saturate.
- Two-stage pipeline with full valid/ready backpressure.
- A saturation event counter supports quantisation debugging.
- All elements of a beat are processed in parallel, lane-independent.

Parameters:
- DATA_IN_0_PRECISION_0, 32: input element width (signed, two's complement).
- DATA_IN_0_PRECISION_1, 8: input fractional bits.
- DATA_OUT_0_PRECISION_0, 16: output element width (signed).
- DATA_OUT_0_PRECISION_1, 4: output fractional bits. Must be <= DATA_IN_0_PRECISION_1; violation is an elaboration error.
- DATA_IN_0_PARALLELISM_DIM_0, 1: elements per beat. Output parallelism is identical.
- SAT_COUNT_WIDTH, 16: width of the saturation counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- data_in_0  in  [DATA_IN_0_PRECISION_0-1:0] x PAR (unpacked array)  input elements.
- data_in_0_valid  in  1  input beat valid.
- data_in_0_ready  out  1  block can accept a beat.
- data_out_0  out  [DATA_OUT_0_PRECISION_0-1:0] x PAR (unpacked array)  requantised elements.
- data_out_0_valid  out  1  output beat valid.
- data_out_0_ready  in  1  downstream accepts the beat.
- sat_clear  in  1  synchronous clear of sat_count.
- sat_count  out  SAT_COUNT_WIDTH  number of saturated elements, sticky at max.

Behaviour:
- Clock and reset: one clock (clk). Reset (rst) is asynchronous and active-low. While rst=0:
  - s1_valid, s2_valid, data_out_0_valid = 0
  - data_out_0 elements = 0
  - sat_count = 0
  - data_in_0_ready = 0
- Reset takes effect immediately, including mid-stream; in-flight beats are discarded.
- Arithmetic, with SHIFT = DATA_IN_0_PRECISION_1 - DATA_OUT_0_PRECISION_1:
  - Stage 1: sign-extend to IN+1 bits. If SHIFT>0, add 2^(SHIFT-1) and arithmetic-shift right by SHIFT. Ties therefore round toward +inf. If SHIFT=0, pass through.
  - Stage 2: clamp to [-2^(OUT-1), 2^(OUT-1)-1], then truncate to OUT bits.
  - A lane is "saturated" if clamping changed its value.
- Pipeline:
  - Stage 1 register: s1_valid, s1_data (IN+1 bits per lane). Stage 2 register drives data_out_0 and data_out_0_valid.
  - adv2 = s1_valid && (!s2_valid || data_out_0_ready)
  - data_in_0_ready = rst && (!s1_valid || adv2), combinational
  - Input handshake when data_in_0_valid && data_in_0_ready.
  - Latency: 2 cycles from input handshake to data_out_0_valid when unstalled. Throughput: 1 beat/cycle.
- Output stall: while data_out_0_valid && !data_out_0_ready, data_out_0 holds stable and data_out_0_valid stays 1.
- Ordering and loss: beats emerge in order with no duplication or loss. Maximum occupancy is 2 beats.
- Simultaneous events: with stage 2 draining and stage 1 advancing in the same cycle, stage 1 may also accept a new beat in that cycle.
- Saturation counter:
  - On adv2, sat_count += popcount(saturated lanes of the beat moving into stage 2).
  - Saturates at 2^SAT_COUNT_WIDTH-1; never wraps.
  - sat_clear=1 sets sat_count to 0 on the next edge and overrides any same-cycle increment.
- data_out_0 is registered. No combinational path from data_in_0 to data_out_0.

Test Plan:
- Rounding, defaults (SHIFT=4):
  - 0x00000018 -> 0x0002
  - 0xFFFFFFE8 -> 0xFFFF
  - 0x00000017 -> 0x0001
  - 0x00000000 -> 0x0000
  - Each appears 2 cycles after acceptance; sat_count stays 0.
- Saturation:
  - 0x00080000 -> 0x7FFF
  - 0xFFF00000 -> 0x8000
  - 0x7FFFFFFF -> 0x7FFF (no adder overflow)
  - sat_count = 3 afterwards; 0x00007FF0 -> 0x07FF with no count increment.
- Backpressure:
  - Hold data_out_0_ready=0 and offer 4 consecutive beats. Exactly 2 are accepted, then data_in_0_ready=0, and data_out_0 is stable every cycle.
  - Raise ready: all 4 beats exit in order, one per cycle, with no bubble in steady state.
- Counter limits:
  - SAT_COUNT_WIDTH=2 with 5 saturating beats -> sat_count sticks at 3.
  - sat_clear asserted in the same cycle as a saturating adv2 -> sat_count=0.
- Reset mid-operation:
  - Drive rst=0 asynchronously (between edges) with both stages full. data_out_0_valid, data_out_0, sat_count and data_in_0_ready go to 0 immediately.
  - After release, the first new beat appears after exactly 2 cycles.
- Parallelism: PAR=4 with lanes {0x18, 0x00080000, 0xFFFFFFE8, 0x0} -> {0x0002, 0x7FFF, 0xFFFF, 0x0000}; sat_count += 1.

Source files
------------

// File: rtl/fixed_softplus_requant.sv
// Requantises the wide fixed-point activation stream to a narrower format:
// round to nearest (ties toward +inf), then saturate. Two-stage pipeline.
//
// Ports:
//   clk, rst           clock, async active-low reset
//   data_in_0[*]       signed input lanes (IN bits, IN_FRAC fraction bits)
//   data_in_0_valid/_ready   input handshake
//   data_out_0[*]      signed output lanes (OUT bits, OUT_FRAC fraction bits)
//   data_out_0_valid/_ready  output handshake
//   sat_clear          synchronous clear of sat_count
//   sat_count          saturated lanes seen, sticky at max
module fixed_softplus_requant #(
  parameter int DATA_IN_0_PRECISION_0       = 32,
  parameter int DATA_IN_0_PRECISION_1       = 8,
  parameter int DATA_OUT_0_PRECISION_0      = 16,
  parameter int DATA_OUT_0_PRECISION_1      = 4,
  parameter int DATA_IN_0_PARALLELISM_DIM_0 = 1,
  parameter int SAT_COUNT_WIDTH             = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic [DATA_IN_0_PRECISION_0-1:0]
               data_in_0 [DATA_IN_0_PARALLELISM_DIM_0],
  input  logic data_in_0_valid,
  output logic data_in_0_ready,
  output logic [DATA_OUT_0_PRECISION_0-1:0]
               data_out_0 [DATA_IN_0_PARALLELISM_DIM_0],
  output logic data_out_0_valid,
  input  logic data_out_0_ready,
  input  logic sat_clear,
  output logic [SAT_COUNT_WIDTH-1:0] sat_count
);

  localparam int IW    = DATA_IN_0_PRECISION_0;
  localparam int OW    = DATA_OUT_0_PRECISION_0;
  localparam int PAR   = DATA_IN_0_PARALLELISM_DIM_0;
  localparam int SCW   = SAT_COUNT_WIDTH;
  localparam int SHIFT = DATA_IN_0_PRECISION_1
                       - DATA_OUT_0_PRECISION_1;
  localparam int EW    = IW + 1;
  localparam int CW    = $clog2(PAR + 1);
  localparam int SW    = SCW + CW;

  if (SHIFT < 0) begin : g_bad_frac
    $error("output fraction bits exceed input fraction bits");
  end
  if (OW > EW || OW < 2) begin : g_bad_width
    $error("output width must be in [2, input width + 1]");
  end

  // Clamp bounds expressed in the widened stage-1 format.
  localparam logic signed [EW-1:0] MAXV =
    {{(EW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [EW-1:0] MINV =
    {{(EW-OW+1){1'b1}}, {(OW-1){1'b0}}};
  localparam logic [SW-1:0] SAT_MAX =
    {{CW{1'b0}}, {SCW{1'b1}}};

  logic s1_valid_q, s1_valid_d;
  logic s2_valid_q, s2_valid_d;
  logic signed [EW-1:0] s1_data_q [PAR];
  logic signed [EW-1:0] s1_data_d [PAR];
  logic [OW-1:0] out_q [PAR];
  logic [OW-1:0] out_d [PAR];
  logic [SCW-1:0] sat_count_q, sat_count_d;

  logic signed [EW-1:0] rnd [PAR];
  logic [OW-1:0] clamp [PAR];
  logic [PAR-1:0] sat;
  logic [CW-1:0] pop;
  logic [SW-1:0] sum_w;
  logic adv2, acc;

  assign adv2 = s1_valid_q
              && (!s2_valid_q || data_out_0_ready);
  assign data_in_0_ready = rst && (!s1_valid_q || adv2);
  assign acc = data_in_0_valid && data_in_0_ready;

  for (genvar g = 0; g < PAR; g++) begin : g_lane
    logic signed [EW-1:0] ext;
    assign ext = {data_in_0[g][IW-1], data_in_0[g]};

    if (SHIFT > 0) begin : g_rnd
      localparam logic signed [EW-1:0] HALF =
        EW'(1) << (SHIFT - 1);
      logic signed [EW-1:0] sum;
      // Cannot overflow: max input + HALF < 2^IW.
      assign sum    = ext + HALF;
      assign rnd[g] = sum >>> SHIFT;
    end else begin : g_pass
      assign rnd[g] = ext;
    end

    always_comb begin
      clamp[g] = s1_data_q[g][OW-1:0];
      sat[g]   = 1'b0;
      if (s1_data_q[g] > MAXV) begin
        clamp[g] = MAXV[OW-1:0];
        sat[g]   = 1'b1;
      end else if (s1_data_q[g] < MINV) begin
        clamp[g] = MINV[OW-1:0];
        sat[g]   = 1'b1;
      end
    end

    assign data_out_0[g] = out_q[g];
  end

  always_comb begin
    pop = '0;
    for (int i = 0; i < PAR; i++) begin
      pop = pop + CW'(sat[i]);
    end
  end

  assign sum_w = SW'(sat_count_q) + SW'(pop);

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s2_valid_d  = s2_valid_q;
    s1_data_d   = s1_data_q;
    out_d       = out_q;
    sat_count_d = sat_count_q;
    if (acc) begin
      s1_valid_d = 1'b1;
      s1_data_d  = rnd;
    end else if (adv2) begin
      s1_valid_d = 1'b0;
    end
    if (adv2) begin
      s2_valid_d = 1'b1;
      out_d      = clamp;
    end else if (data_out_0_ready) begin
      s2_valid_d = 1'b0;
    end
    // Clear wins over a same-cycle increment.
    if (sat_clear) begin
      sat_count_d = '0;
    end else if (adv2) begin
      if (sum_w > SAT_MAX) begin
        sat_count_d = '1;
      end else begin
        sat_count_d = sum_w[SCW-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      sat_count_q <= '0;
      for (int i = 0; i < PAR; i++) begin
        s1_data_q[i] <= '0;
        out_q[i]     <= '0;
      end
    end else begin
      s1_valid_q  <= s1_valid_d;
      s2_valid_q  <= s2_valid_d;
      sat_count_q <= sat_count_d;
      s1_data_q   <= s1_data_d;
      out_q       <= out_d;
    end
  end

  assign data_out_0_valid = s2_valid_q;
  assign sat_count        = sat_count_q;

endmodule
